sargantana_icache_refill_buffer: RTL and testbench
==================================================

SARGANTANA_ICACHE_REFILL_BUFFER -- requirements
Module: sargantana_icache_refill_buffer

Interface
REQ-001 Parameter: BEAT_WIDTH, default 128, width in bits of one L2 response beat.
REQ-002 Parameter: PADDR_WIDTH, default 40, physical address width in bits.
REQ-003 Derived constants SHALL be N_BEATS = WAY_WIDHT/BEAT_WIDTH (default 4) and the beat counter width $clog2(N_BEATS); WAY_WIDHT (512) SHALL come from sargantana_icache_pkg.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be, in this order:
- clk_i, in, 1: clock.
- rstn_i, in, 1: asynchronous active-low reset.
- miss_i, in, 1: pulse; starts a line refill.
- miss_paddr_i, in, PADDR_WIDTH: miss physical address.
- kill_i, in, 1: abandon the current refill (pipeline flush).
- l2_req_valid_o, out, 1: L2 request valid.
- l2_req_ready_i, in, 1: L2 accepts the request.
- l2_req_addr_o, out, PADDR_WIDTH: line-aligned request address; low $clog2(WAY_WIDHT/8) bits are zero.
- l2_resp_valid_i, in, 1: response beat valid, in order, beat 0 first; no backpressure.
- l2_resp_data_i, in, BEAT_WIDTH: response beat.
- ifill_valid_o, out, 1: one-cycle pulse; line complete.
- ifill_data_o, out, WAY_WIDHT: assembled line; feeds the tag/data checker ifill_data_i.
- ifill_paddr_o, out, PADDR_WIDTH: line-aligned address of the filled line.
- busy_o, out, 1: refill in progress (state != IDLE).

Function
REQ-006 The FSM SHALL have exactly four states: IDLE, REQ, COLLECT, DRAIN.
REQ-007 In IDLE, miss_i=1 and kill_i=0 SHALL latch the line-aligned miss_paddr_i, clear the beat counter, and go to REQ next cycle; miss_i with kill_i=1 SHALL be ignored.
REQ-008 In REQ, l2_req_valid_o SHALL be 1 and l2_req_addr_o SHALL hold the latched address stable until l2_req_valid_o & l2_req_ready_i, which SHALL move the FSM to COLLECT.
REQ-009 In COLLECT, each l2_resp_valid_i beat SHALL be written to line bits [k*BEAT_WIDTH +: BEAT_WIDTH], where k is the beat counter, and k SHALL increment by 1.
REQ-010 On the beat with k = N_BEATS-1, the next cycle SHALL assert ifill_valid_o for exactly one cycle, with the complete line on ifill_data_o and the latched address on ifill_paddr_o; the FSM SHALL return to IDLE in that same cycle.
REQ-011 Latency: with ready and beats back-to-back, ifill_valid_o SHALL rise exactly 1 cycle after the last beat is accepted.
REQ-012 ifill_data_o and ifill_paddr_o SHALL hold their values until the next refill's first beat or address latch; they SHALL not be valid outside the ifill_valid_o pulse.
REQ-013 kill_i in REQ SHALL take priority over l2_req_ready_i in the same cycle:
- if the handshake happened in that same cycle, go to DRAIN;
- otherwise go to IDLE without issuing the request, and drop l2_req_valid_o next cycle.
REQ-014 kill_i in COLLECT SHALL move the FSM to DRAIN; the beat in that cycle SHALL still be counted.
REQ-015 In DRAIN, remaining beats SHALL be counted and discarded without a write; after beat N_BEATS-1 the FSM SHALL go to IDLE; ifill_valid_o SHALL never assert for a killed refill.
REQ-016 miss_i while busy_o=1 SHALL be ignored; a new refill SHALL need miss_i in IDLE, so the earliest is the cycle after the ifill_valid_o pulse.
REQ-017 l2_resp_valid_i in IDLE or REQ SHALL be ignored and change no state.
REQ-018 The beat counter SHALL wrap from N_BEATS-1 to 0.
REQ-019 kill_i in IDLE SHALL have no effect.

Reset
REQ-020 While rstn_i=0, and asynchronously on assertion, the block SHALL be:
- state = IDLE;
- l2_req_valid_o = 0, ifill_valid_o = 0, busy_o = 0;
- l2_req_addr_o = 0, ifill_paddr_o = 0, ifill_data_o = 0;
- beat counter = 0.
REQ-021 Reset asserted mid-refill SHALL abandon it with no ifill_valid_o; beats arriving after reset release SHALL be ignored per REQ-017.

Verification
REQ-022 Basic refill: miss_paddr_i=0x80001234, ready=1 -> l2_req_addr_o=0x80001200; beats 0x0..0,0x1..1,0x2..2,0x3..3 -> ifill_data_o = {beat3,beat2,beat1,beat0}, one-cycle ifill_valid_o one cycle after beat3.
REQ-023 Backpressure: ready held 0 for 5 cycles -> l2_req_valid_o=1 with stable address for 5 cycles, handshake on cycle 6.
REQ-024 Gapped beats, 2 idle cycles between each beat -> line correct; ifill_valid_o exactly once.
REQ-025 kill_i after beat 1 -> beats 2,3 discarded; no ifill_valid_o; busy_o=0 after beat 3; next miss refills correctly.
REQ-026 kill_i and ready in the same REQ cycle -> DRAIN, 4 beats absorbed, no fill; kill_i alone in REQ -> IDLE next cycle, no L2 handshake.
REQ-027 rstn_i=0 mid-COLLECT -> all outputs 0 immediately; stray beats after release ignored; miss_i while busy ignored.

Source files
------------

// File: rtl/sargantana_icache_refill_buffer.sv
// Instruction-cache refill buffer: issues one line request to L2, assembles the
// in-order response beats into a full line and hands it to the tag/data checker.

package sargantana_icache_pkg;
  localparam int WAY_WIDHT = 512;
endpackage

module sargantana_icache_refill_buffer
  import sargantana_icache_pkg::*;
#(
  parameter int BEAT_WIDTH  = 128,
  parameter int PADDR_WIDTH = 40
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   miss_i,
  input  logic [PADDR_WIDTH-1:0] miss_paddr_i,
  input  logic                   kill_i,
  output logic                   l2_req_valid_o,
  input  logic                   l2_req_ready_i,
  output logic [PADDR_WIDTH-1:0] l2_req_addr_o,
  input  logic                   l2_resp_valid_i,
  input  logic [BEAT_WIDTH-1:0]  l2_resp_data_i,
  output logic                   ifill_valid_o,
  output logic [WAY_WIDHT-1:0]   ifill_data_o,
  output logic [PADDR_WIDTH-1:0] ifill_paddr_o,
  output logic                   busy_o
);

  localparam int N_BEATS  = WAY_WIDHT / BEAT_WIDTH;
  localparam int CNT_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int OFFSET_W = $clog2(WAY_WIDHT / 8);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    COLLECT,
    DRAIN
  } state_e;

  state_e                 r_state;
  state_e                 w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [PADDR_WIDTH-1:0] r_addr;
  logic [WAY_WIDHT-1:0]   r_line;
  logic                   r_fill_valid;

  logic                   w_accept_miss;
  logic                   w_beat_counted;
  logic                   w_last_beat;
  logic                   w_write_beat;
  logic                   w_fill;
  logic [PADDR_WIDTH-1:0] w_line_addr;

  assign w_line_addr    = {miss_paddr_i[PADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign w_accept_miss  = (r_state == IDLE) && miss_i && !kill_i;
  assign w_beat_counted = l2_resp_valid_i && ((r_state == COLLECT) || (r_state == DRAIN));
  assign w_last_beat    = w_beat_counted && (r_cnt == LAST_BEAT);
  assign w_write_beat   = l2_resp_valid_i && (r_state == COLLECT);
  // A kill arriving with the final beat still abandons the line.
  assign w_fill         = w_write_beat && (r_cnt == LAST_BEAT) && !kill_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: next state is defaulted to the current state first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept_miss) w_next_state = REQ;
      end
      REQ: begin
        if (kill_i) begin
          // A handshake in the kill cycle means L2 will still send the line.
          w_next_state = l2_req_ready_i ? DRAIN : IDLE;
        end else if (l2_req_ready_i) begin
          w_next_state = COLLECT;
        end
      end
      COLLECT: begin
        if (w_last_beat)  w_next_state = IDLE;
        else if (kill_i)  w_next_state = DRAIN;
      end
      DRAIN: begin
        if (w_last_beat) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_fill_valid <= 1'b0;
    end else begin
      r_fill_valid <= w_fill;
      if (w_accept_miss) begin
        r_addr <= w_line_addr;
        r_cnt  <= '0;
      end else if (w_beat_counted) begin
        r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
      end
    end
  end

  // NOTE: the line storage is reset because its reset value is visible on
  // ifill_data_o; pure data storage would normally be left unreset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_line <= '0;
    end else if (w_write_beat) begin
      for (int b = 0; b < N_BEATS; b++) begin
        if (r_cnt == CNT_W'(b)) r_line[b*BEAT_WIDTH +: BEAT_WIDTH] <= l2_resp_data_i;
      end
    end
  end

  assign l2_req_valid_o = (r_state == REQ);
  assign l2_req_addr_o  = r_addr;
  assign ifill_valid_o  = r_fill_valid;
  assign ifill_data_o   = r_line;
  assign ifill_paddr_o  = r_addr;
  assign busy_o         = (r_state != IDLE);

endmodule

// File: tb/tb_sargantana_icache_refill_buffer.sv
// Self-checking bench for the icache refill buffer: directed scenarios plus
// randomized refills checked against a transaction-level line/address model.

module tb_sargantana_icache_refill_buffer;

  localparam int BW  = 128;
  localparam int AW  = 40;
  localparam int LW  = 512;
  localparam int NB  = LW / BW;
  localparam logic [AW-1:0] OFFS_MASK = AW'(LW / 8 - 1);

  logic          clk = 1'b0;
  logic          rstn;
  logic          miss;
  logic [AW-1:0] miss_paddr;
  logic          kill;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic [BW-1:0] resp_data;
  logic          fill_valid;
  logic [LW-1:0] fill_data;
  logic [AW-1:0] fill_paddr;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int fill_cnt = 0;

  // Model of what the consumer side should currently see.
  logic [BW-1:0] mdl_beat [NB];
  logic [AW-1:0] mdl_paddr;

  sargantana_icache_refill_buffer #(.BEAT_WIDTH(BW), .PADDR_WIDTH(AW)) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .miss_i         (miss),
    .miss_paddr_i   (miss_paddr),
    .kill_i         (kill),
    .l2_req_valid_o (req_valid),
    .l2_req_ready_i (req_ready),
    .l2_req_addr_o  (req_addr),
    .l2_resp_valid_i(resp_valid),
    .l2_resp_data_i (resp_data),
    .ifill_valid_o  (fill_valid),
    .ifill_data_o   (fill_data),
    .ifill_paddr_o  (fill_paddr),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (fill_valid === 1'b1) fill_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[AW-1:0];
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [LW-1:0] mdl_line();
    logic [LW-1:0] l;
    for (int k = 0; k < NB; k++) l[k*BW +: BW] = mdl_beat[k];
    return l;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < NB; k++) mdl_beat[k] = '0;
    mdl_paddr = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":req_valid"}, req_valid, 0);
    check({tag, ":fill_valid"}, fill_valid, 0);
    check({tag, ":fill_data"}, fill_data, mdl_line());
    check({tag, ":fill_paddr"}, fill_paddr, mdl_paddr);
  endtask

  // One refill transaction. kill_at: -1 none; 2k = kill together with beat k;
  // 2k+1 = kill alone in an extra cycle after beat k. noise pulses stray misses.
  task automatic refill(input string tag, input logic [AW-1:0] pa, input int rdelay,
                        input int gap, input int kill_at, input logic [LW-1:0] line,
                        input bit noise);
    int            fills0;
    bit            killed;
    logic [AW-1:0] la;
    logic [BW-1:0] b;
    la     = pa & ~OFFS_MASK;
    fills0 = fill_cnt;
    killed = 1'b0;

    miss_paddr = pa;
    miss = 1'b1;
    tick();
    miss = 1'b0;
    mdl_paddr = la;
    check({tag, ":busy_req"}, busy, 1);
    check({tag, ":req_addr"}, req_addr, la);

    req_ready = 1'b0;
    for (int i = 0; i < rdelay; i++) begin
      check({tag, ":req_hold_valid"}, req_valid, 1);
      check({tag, ":req_hold_addr"}, req_addr, la);
      if (noise) begin
        miss = 1'($urandom_range(0, 1));
        miss_paddr = rand_addr();
      end
      tick();
    end
    req_ready = 1'b1;
    check({tag, ":req_valid_hs"}, req_valid, 1);
    tick();
    req_ready = 1'b0;
    miss = 1'b0;
    check({tag, ":req_dropped"}, req_valid, 0);
    check({tag, ":busy_collect"}, busy, 1);

    for (int k = 0; k < NB; k++) begin
      for (int g = 0; g < gap; g++) begin
        if (noise) begin
          miss = 1'($urandom_range(0, 1));
          miss_paddr = rand_addr();
        end
        tick();
        check({tag, ":gap_no_fill"}, fill_valid, 0);
      end
      if (k > 0 && kill_at == 2 * k - 1) begin
        kill = 1'b1;
        tick();
        kill = 1'b0;
        killed = 1'b1;
      end
      b = line[k*BW +: BW];
      resp_valid = 1'b1;
      resp_data  = b;
      kill = (kill_at == 2 * k);
      if (!killed) mdl_beat[k] = b;
      if (kill_at == 2 * k) killed = 1'b1;
      tick();
      resp_valid = 1'b0;
      kill = 1'b0;
      miss = 1'b0;
      if (k < NB - 1) begin
        check({tag, ":beat_no_fill"}, fill_valid, 0);
        check({tag, ":beat_busy"}, busy, 1);
      end
    end

    if (!killed) begin
      check({tag, ":fill_pulse"}, fill_valid, 1);
      check({tag, ":fill_data"}, fill_data, line);
      check({tag, ":fill_paddr"}, fill_paddr, la);
      check({tag, ":busy_at_fill"}, busy, 0);
    end else begin
      check({tag, ":killed_no_fill"}, fill_valid, 0);
      check({tag, ":killed_busy"}, busy, 0);
      check({tag, ":killed_data"}, fill_data, mdl_line());
    end
    tick();
    check_idle_outputs({tag, ":after"});
    check({tag, ":fill_count"}, fill_cnt - fills0, killed ? 0 : 1);
  endtask

  initial begin
    logic [LW-1:0] basic_line;
    logic [AW-1:0] la;

    rstn = 1'b0; miss = 1'b0; miss_paddr = '0; kill = 1'b0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    mdl_reset();

    // Reset state
    #12;
    check("rst:req_addr", req_addr, 0);
    check_idle_outputs("rst");
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // kill alone in IDLE, and miss together with kill in IDLE: both ignored
    kill = 1'b1;
    tick();
    miss = 1'b1; miss_paddr = 40'h12_3456_7890;
    tick();
    miss = 1'b0; kill = 1'b0;
    check_idle_outputs("idle_kill");

    // Basic refill
    basic_line = {{32{4'h3}}, {32{4'h2}}, {32{4'h1}}, {32{4'h0}}};
    refill("basic", 40'h00_8000_1234, 0, 0, -1, basic_line, 1'b0);

    // Backpressure: ready low for 5 cycles
    refill("bp", 40'h00_0000_ABCD, 5, 0, -1, rand_line(), 1'b0);

    // Gapped beats
    refill("gap", 40'hFF_FFFF_FFFF, 1, 2, -1, rand_line(), 1'b0);

    // kill after beat 1 (alone), then a clean refill
    refill("kill_b1", 40'h01_0000_0040, 0, 0, 3, rand_line(), 1'b0);
    refill("post_kill", 40'h01_0000_0080, 0, 1, -1, rand_line(), 1'b0);

    // kill with the final beat
    refill("kill_last", 40'h02_0000_0100, 0, 0, 6, rand_line(), 1'b0);

    // kill and ready in the same REQ cycle: DRAIN absorbs 4 beats
    la = 40'h03_0000_0000;
    miss_paddr = 40'h03_0000_003F; miss = 1'b1;
    tick();
    miss = 1'b0;
    mdl_paddr = la;
    req_ready = 1'b1; kill = 1'b1;
    tick();
    req_ready = 1'b0; kill = 1'b0;
    check("kill_hs:busy", busy, 1);
    check("kill_hs:req_valid", req_valid, 0);
    for (int k = 0; k < NB; k++) begin
      resp_valid = 1'b1; resp_data = {4{$urandom()}};
      tick();
      resp_valid = 1'b0;
      check("kill_hs:no_fill", fill_valid, 0);
    end
    check_idle_outputs("kill_hs:end");

    // kill alone in REQ: back to IDLE, stray beats ignored
    miss_paddr = 40'h04_0000_1000; miss = 1'b1;
    tick();
    miss = 1'b0;
    mdl_paddr = 40'h04_0000_1000;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check_idle_outputs("kill_req");
    resp_valid = 1'b1; resp_data = '1;
    tick();
    tick();
    resp_valid = 1'b0;
    check_idle_outputs("stray_idle");

    // Reset asserted mid-COLLECT
    miss_paddr = 40'h05_0000_2000; miss = 1'b1;
    tick();
    miss = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      resp_valid = 1'b1; resp_data = {4{$urandom()}};
      tick();
    end
    resp_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    mdl_reset();
    check("midrst:req_addr", req_addr, 0);
    check_idle_outputs("midrst");
    tick();
    rstn = 1'b1;
    for (int k = 0; k < NB; k++) begin
      resp_valid = 1'b1; resp_data = {4{$urandom()}};
      tick();
    end
    resp_valid = 1'b0;
    check_idle_outputs("post_rst_stray");

    // Randomized refills with stray misses while busy
    for (int n = 0; n < 40; n++) begin
      int ka;
      ka = ($urandom_range(0, 9) < 7) ? -1 : int'($urandom_range(0, 6));
      refill("rnd", rand_addr(), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             ka, rand_line(), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
